// File: rtl/addsub_cla_pipe.sv
// Pipelined W-bit adder/subtractor. Each stage resolves one BLK-bit carry-lookahead group,
// with optional signed saturation and C/V/Z/N flags, behind a global-stall valid/ready pipe.
module addsub_cla_pipe #(
  parameter int W   = 16,
  parameter int BLK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         M,
  input  logic         SAT,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         C,
  output logic         V,
  output logic         Z,
  output logic         N
);

  localparam int NS = W / BLK;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = ~SMAX;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] bp;    // B already inverted for subtract
    logic [W-1:0] s;     // sum bits resolved so far
    logic         c;     // carry into the next unresolved group
    logic         cmsb;  // carry into bit W-1
    logic         m;
    logic         sat;
  } stage_t;

  // Flattened lookahead: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]cin
  function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] g,
                                               input logic [BLK-1:0] p,
                                               input logic           cin);
    logic [BLK:0] cv;
    logic         term;
    cv    = '0;
    cv[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      cv[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int l = j + 1; l <= i; l++) term = term & p[l];
        cv[i+1] = cv[i+1] | term;
      end
    end
    return cv;
  endfunction

  stage_t         p_q [NS];
  stage_t         nxt [NS];
  logic [BLK-1:0] grp_p [NS];
  logic [BLK-1:0] grp_g [NS];
  logic [BLK:0]   grp_c [NS];

  logic         out_valid_q;
  logic [W-1:0] s_q;
  logic         c_q, v_q, z_q, n_q;
  logic         en;
  logic         v_raw;
  logic [W-1:0] s_fin;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en && !rst;
  assign out_valid = out_valid_q;
  assign S = s_q;
  assign C = c_q;
  assign V = v_q;
  assign Z = z_q;
  assign N = n_q;

  // NOTE: every stage starts from a full copy of its input register, so no path through
  // this block leaves a field unassigned and no latch can be inferred.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      grp_p[k] = p_q[k].a[k*BLK +: BLK] ^ p_q[k].bp[k*BLK +: BLK];
      grp_g[k] = p_q[k].a[k*BLK +: BLK] & p_q[k].bp[k*BLK +: BLK];
      grp_c[k] = cla_carries(grp_g[k], grp_p[k], p_q[k].c);
      nxt[k]   = p_q[k];
      nxt[k].s[k*BLK +: BLK] = grp_p[k] ^ grp_c[k][BLK-1:0];
      nxt[k].c = grp_c[k][BLK];
    end
    nxt[NS-1].cmsb = grp_c[NS-1][BLK-1];
  end

  // Saturate toward the sign of A: with Bp pre-inverted, add and subtract overflow alike.
  always_comb begin
    v_raw = nxt[NS-1].c ^ nxt[NS-1].cmsb;
    s_fin = nxt[NS-1].s;
    if (nxt[NS-1].sat && v_raw) s_fin = p_q[NS-1].a[W-1] ? SMIN : SMAX;
  end

  // NOTE: only the valid bits need reset; stage payloads are don't-care while invalid,
  // so they are left unreset to keep the wide datapath flops reset-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) p_q[k].valid <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
    end else if (en) begin
      p_q[0] <= '{valid: in_valid, a: A, bp: (M ? ~B : B), s: '0,
                  c: M, cmsb: 1'b0, m: M, sat: SAT};
      for (int k = 1; k < NS; k++) p_q[k] <= nxt[k-1];
      out_valid_q <= nxt[NS-1].valid;
      if (nxt[NS-1].valid) begin
        s_q <= s_fin;
        c_q <= nxt[NS-1].c;
        v_q <= v_raw;
        z_q <= (s_fin == '0);
        n_q <= s_fin[W-1];
      end
    end
  end

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Self-checking bench for addsub_cla_pipe: signed/unsigned integer reference model,
// directed vectors with literal expectations, streaming, backpressure and mid-flight reset.
module tb_addsub_cla_pipe;

  localparam int W      = 16;
  localparam int BLK    = 4;
  localparam int NS     = W / BLK;
  localparam int SMAX_I = 2**(W-1) - 1;
  localparam int SMIN_I = -(2**(W-1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B, S;
  logic         M, SAT;
  logic         out_valid, out_ready;
  logic         C, V, Z, N;

  always #5 clk = ~clk;

  addsub_cla_pipe #(.W(W), .BLK(BLK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .M(M), .SAT(SAT),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .C(C), .V(V), .Z(Z), .N(N)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c, v, z, n;
  } res_t;

  res_t exp_q[$];
  int   out_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out    = 0;

  task automatic check_s(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_i(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' signed and unsigned values.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input logic sat);
    int   sa, sb, ua, ub, r;
    res_t res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = m ? (sa - sb) : (sa + sb);
    res.v = (r > SMAX_I) || (r < SMIN_I);
    res.c = m ? (ua >= ub) : ((ua + ub) >= 2**W);
    if (sat && res.v) res.s = (r > SMAX_I) ? W'(SMAX_I) : W'(SMIN_I);
    else              res.s = r[W-1:0];
    res.z = (res.s == '0);
    res.n = res.s[W-1];
    return res;
  endfunction

  always @(posedge clk) cyc++;

  // An item presented with in_ready high at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (in_valid && in_ready) exp_q.push_back(model(A, B, M, SAT));
  end

  always @(negedge clk) begin
    res_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got S=0x%0h with no item outstanding (t=%0t)", S, $time);
      end else begin
        e = exp_q.pop_front();
        check_s("S", S, e.s);
        check_b("C", C, e.c);
        check_b("V", V, e.v);
        check_b("Z", Z, e.z);
        check_b("N", N, e.n);
      end
      n_out++;
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic sat);
    int n;
    A = a; B = b; M = m; SAT = sat;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_b("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_i("drain", exp_q.size(), 0);
  endtask

  task automatic run_one(input string name,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic sat,
                         input logic [W-1:0] es, input logic ec, input logic ev,
                         input logic ez, input logic en);
    res_t pm;
    int   n;
    pm = model(a, b, m, sat);
    check_s({name, "_model_S"}, pm.s, es);
    check_b({name, "_model_V"}, pm.v, ev);
    send(a, b, m, sat);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_i({name, "_latency"}, n, NS);
    check_s({name, "_S"}, S, es);
    check_b({name, "_C"}, C, ec);
    check_b({name, "_V"}, V, ev);
    check_b({name, "_Z"}, Z, ez);
    check_b({name, "_N"}, N, en);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] snap_s;
    logic         snap_c, snap_v, snap_z, snap_n;
    int           base, base_c;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; M = 1'b0; SAT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_b("in_ready_during_reset", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_b("reset_in_ready", in_ready, 1'b1);
    check_b("reset_out_valid", out_valid, 1'b0);
    check_s("reset_S", S, '0);
    check_b("reset_C", C, 1'b0);
    check_b("reset_V", V, 1'b0);
    check_b("reset_Z", Z, 1'b0);
    check_b("reset_N", N, 1'b0);
    @(posedge clk);
    #1;

    run_one("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_one("add_sat",     16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("sub_zero",    16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("sub_neg",     16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("sub_sat_min", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    run_one("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream with the sink always ready.
    base   = n_out;
    base_c = out_cyc.size();
    for (int i = 0; i < 8; i++) begin
      A = W'($urandom); B = W'($urandom); M = 1'($urandom); SAT = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check_b("stream_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check_i("stream_count", n_out - base, 8);
    if (out_cyc.size() >= base_c + 8)
      check_i("stream_span", out_cyc[base_c + 7] - out_cyc[base_c], 7);
    else
      check_i("stream_span_count", out_cyc.size() - base_c, 8);

    // Fill the pipe with the sink stalled, then hold it for 5 cycles.
    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < NS + 1; i++)
      send(W'(16'h1100 * (i + 1)), W'(16'h0F01 + i), 1'(i % 2), 1'b0);
    check_b("bp_full_out_valid", out_valid, 1'b1);
    snap_s = S; snap_c = C; snap_v = V; snap_z = Z; snap_n = N;
    A = 16'h4000; B = 16'h4000; M = 1'b0; SAT = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_b("bp_in_ready", in_ready, 1'b0);
      check_b("bp_out_valid", out_valid, 1'b1);
      check_s("bp_S_hold", S, snap_s);
      check_b("bp_C_hold", C, snap_c);
      check_b("bp_V_hold", V, snap_v);
      check_b("bp_Z_hold", Z, snap_z);
      check_b("bp_N_hold", N, snap_n);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_b("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    @(posedge clk);
    #1;
    check_i("bp_count", n_out - base, NS + 2);

    // Reset with three items in flight: they must vanish.
    for (int i = 0; i < 3; i++) begin
      A = W'(16'h0101 * (i + 3)); B = W'(16'h0011 * (i + 1)); M = 1'b0; SAT = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_b("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_s("rst_S", S, '0);
    check_b("rst_C", C, 1'b0);
    check_b("rst_V", V, 1'b0);
    check_b("rst_Z", Z, 1'b0);
    check_b("rst_N", N, 1'b0);
    check_b("rst_release_in_ready", in_ready, 1'b1);
    run_one("post_rst", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (NS + 2) @(posedge clk);
    #1;
    check_i("final_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
